uart_tx_fifo_arbiter: RTL

Round-robin arbiter that shares the single UART transmit FWFT FIFO between up to NUM_REQ byte-stream requesters (e.g. command responder, debug console, status reporter). It grants one requester at a time and holds the grant until that requester's message ends. This keeps multi-byte messages contiguous in the FIFO. It sits between the requester logic and the write side of the synchronous FWFT FIFO, and drives the FIFO write enable and data directly.

---
 rtl/uart_tx_fifo_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO write port between NUM_REQ byte streams.
// Grant is held for a whole message; define UART_TX_ARB_WATCHDOG_EN to add a stall-release watchdog.
module uart_tx_fifo_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   arb_clk_i,
    input  logic                   arb_rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*8-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   fifo_wr_en_o,
    output logic [7:0]             fifo_data_o,
    input  logic                   fifo_full_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic                   busy_o,
    output logic                   timeout_o
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   cand, pick;
    logic               found;
    logic               accept;
    logic               wd_fire;
    logic [7:0]         lane_data [NUM_REQ];

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
            $error("uart_tx_fifo_arbiter: parameter out of range");
        end
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane_data[gi] = req_data_i[8*gi +: 8];
        end
    endgenerate

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] v);
        return (v == IDX_W'(NUM_REQ - 1)) ? '0 : v + 1'b1;
    endfunction

    // Reset blanks the byte path in the reset cycle itself, not just from the next one.
    assign accept = (state_q == ST_BUSY) & req_valid_i[gnt_idx_q] & ~fifo_full_i & ~arb_rst_i;

`ifdef UART_TX_ARB_WATCHDOG_EN
    localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic       stall_cyc;

    // Only an empty lane counts as a stall; a full FIFO freezes the count.
    assign stall_cyc = (state_q == ST_BUSY) & ~req_valid_i[gnt_idx_q] & ~fifo_full_i;
    assign wd_fire   = stall_cyc & (stall_cnt_q == STALL_LIMIT) & ~arb_rst_i;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q != ST_BUSY || accept) begin
            stall_cnt_d = '0;
        end else if (stall_cyc) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge arb_clk_i) begin
        if (arb_rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge arb_clk_i) begin
        if (arb_rst_i) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            gnt_idx_q <= '0;
            gnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_q     <= gnt_d;
        end
    end

    always_comb begin
        found     = 1'b0;
        pick      = rr_ptr_q;
        cand      = rr_ptr_q;
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_idx_d = gnt_idx_q;
        gnt_d     = gnt_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = next_idx(cand);
        end
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d   = ST_BUSY;
                    gnt_idx_d = pick;
                    gnt_d     = NUM_REQ'(1) << pick;
                end
            end
            ST_BUSY: begin
                if ((accept && req_last_i[gnt_idx_q]) || wd_fire) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_idx(gnt_idx_q);
                    gnt_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = '0;
        fifo_wr_en_o = 1'b0;
        fifo_data_o  = 8'h00;
        if (accept) begin
            req_ready_o  = gnt_q;
            fifo_wr_en_o = 1'b1;
            fifo_data_o  = lane_data[gnt_idx_q];
        end
        gnt_o     = gnt_q;
        busy_o    = (state_q == ST_BUSY);
        timeout_o = wd_fire;
    end
endmodule
